key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_cond_pkg.sv | 21 ++
 rtl/key_debounce.sv | 108 ++++++++++
 rtl/key_conditioner.sv | 66 ++++++
 tb/tb_key_conditioner.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_cond_pkg.sv
// +--------------------------------------------------------------------------+
// | key_cond_pkg : shared types and constants for the key conditioner       |
// | Revision 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package key_cond_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  localparam int DB_SHORT_CYCLES = 4;
  localparam int DB_CNT_W        = 20;

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// +--------------------------------------------------------------------------+
// | key_debounce : sync + debounce FSM + press strobe for one active-low key|
// | Revision 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module key_debounce
  import key_cond_pkg::*;
#(
  parameter int DB_COUNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_raw,
  output logic level,
  output logic pulse
);

  localparam logic [DB_CNT_W-1:0] LAST_CNT = DB_CNT_W'(DB_COUNT - 1);

  logic                sync1;
  logic                sync2;
  db_state_t           state;
  db_state_t           state_nxt;
  logic [DB_CNT_W-1:0] cnt;
  logic [DB_CNT_W-1:0] cnt_nxt;
  logic [DB_CNT_W-1:0] cnt_inc;
  logic                level_nxt;
  logic                pulse_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n_raw;
      sync2 <= sync1;
    end
  end

  // Saturating increment so a pathological count can never wrap back to zero.
  assign cnt_inc = (cnt == {DB_CNT_W{1'b1}}) ? cnt : cnt + DB_CNT_W'(1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RELEASED: begin
        if (!sync2) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (sync2) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc >= LAST_CNT) begin
            state_nxt = PRESSED;
          end
        end
      end
      PRESSED: begin
        if (sync2) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!sync2) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc >= LAST_CNT) begin
            state_nxt = RELEASED;
          end
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
      end
    endcase
    // Outputs are decoded from the next state so they register on the same edge.
    level_nxt = (state_nxt == RELEASED) || (state_nxt == PRESS_WAIT);
    pulse_nxt = (state == PRESS_WAIT) && (state_nxt == PRESSED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RELEASED;
      cnt   <= '0;
      level <= 1'b1;
      pulse <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
      pulse <= pulse_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/key_conditioner.sv
// +--------------------------------------------------------------------------+
// | key_conditioner : debounced Run/Continue keys and synchronized switches |
// | Option: DEBOUNCE_SHORT_EN forces a short debounce count for simulation  |
// | Revision 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int DB_CYCLES = 500000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run_n_raw,
  input  logic        Continue_n_raw,
  input  logic [15:0] S_raw,
  output logic        Run,
  output logic        Continue,
  output logic        Run_pulse,
  output logic        Continue_pulse,
  output logic [15:0] S
);

`ifdef DEBOUNCE_SHORT_EN
  localparam int EFF_DB_COUNT = DB_SHORT_CYCLES;
`else
  localparam int EFF_DB_COUNT = DB_CYCLES;
`endif

  logic [15:0] s_meta;

  key_debounce #(
    .DB_COUNT (EFF_DB_COUNT)
  ) u_run_db (
    .clk       (Clk),
    .rst       (Reset),
    .key_n_raw (Run_n_raw),
    .level     (Run),
    .pulse     (Run_pulse)
  );

  key_debounce #(
    .DB_COUNT (EFF_DB_COUNT)
  ) u_cont_db (
    .clk       (Clk),
    .rst       (Reset),
    .key_n_raw (Continue_n_raw),
    .level     (Continue),
    .pulse     (Continue_pulse)
  );

  // Switches are static in use, so a plain per-bit synchronizer suffices.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s_meta <= 16'h0000;
      S      <= 16'h0000;
    end else begin
      s_meta <= S_raw;
      S      <= s_meta;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_key_conditioner.sv
// +--------------------------------------------------------------------------+
// | tb_key_conditioner : directed and random checks against a run-length    |
// | debounce model; Revision 1.0                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_key_conditioner;

  localparam int N = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Run_n_raw = 1'b1;
  logic        Continue_n_raw = 1'b1;
  logic [15:0] S_raw = 16'h0000;
  logic        Run;
  logic        Continue;
  logic        Run_pulse;
  logic        Continue_pulse;
  logic [15:0] S;

  key_conditioner #(.DB_CYCLES(N)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Run_n_raw      (Run_n_raw),
    .Continue_n_raw (Continue_n_raw),
    .S_raw          (S_raw),
    .Run            (Run),
    .Continue       (Continue),
    .Run_pulse      (Run_pulse),
    .Continue_pulse (Continue_pulse),
    .S              (S)
  );

  always #5 Clk = ~Clk;

  int nchk = 0;
  int nerr = 0;

  // Model: raw keys seen through a 2-sample delay; the stable level flips once
  // N consecutive delayed samples disagree with it.
  bit          d1[2];
  bit          d2[2];
  bit          lvl[2];
  bit          pls[2];
  int          run[2];
  logic [15:0] sd1;
  logic [15:0] sd2;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      d1[k] = 1'b1; d2[k] = 1'b1; lvl[k] = 1'b1; pls[k] = 1'b0; run[k] = 0;
    end
    sd1 = 16'h0000;
    sd2 = 16'h0000;
  endtask

  task automatic model_edge();
    bit raw[2];
    bit ev;
    raw[0] = Run_n_raw;
    raw[1] = Continue_n_raw;
    for (int k = 0; k < 2; k++) begin
      ev = d2[k];
      d2[k] = d1[k];
      d1[k] = raw[k];
      pls[k] = 1'b0;
      if (ev != lvl[k]) begin
        run[k] = run[k] + 1;
        if (run[k] >= N) begin
          lvl[k] = ev;
          run[k] = 0;
          pls[k] = (ev == 1'b0);
        end
      end else begin
        run[k] = 0;
      end
    end
    sd2 = sd1;
    sd1 = S_raw;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("Run", {15'd0, Run}, {15'd0, lvl[0]});
    check("Continue", {15'd0, Continue}, {15'd0, lvl[1]});
    check("Run_pulse", {15'd0, Run_pulse}, {15'd0, pls[0]});
    check("Continue_pulse", {15'd0, Continue_pulse}, {15'd0, pls[1]});
    check("S", S, sd2);
  endtask

  task automatic step();
    @(posedge Clk);
    if (Reset) model_reset();
    else model_edge();
    #1;
    compare_all();
  endtask

  int npulse;

  initial begin
    // Reset with keys released
    #1;
    Reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    step();
    step();
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("idle_S", S, 16'h0000);

    // Clean Run press held 12 cycles, then release
    Run_n_raw = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("run_before_fall", {15'd0, Run}, 16'd1);
    end
    step();
    check("run_fall_edge6", {15'd0, Run}, 16'd0);
    check("run_pulse_edge6", {15'd0, Run_pulse}, 16'd1);
    for (int i = 7; i <= 12; i++) begin
      step();
      check("run_held", {15'd0, Run}, 16'd0);
      check("run_pulse_once", {15'd0, Run_pulse}, 16'd0);
    end
    Run_n_raw = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("run_before_rise", {15'd0, Run}, 16'd0);
      check("release_no_pulse", {15'd0, Run_pulse}, 16'd0);
    end
    step();
    check("run_rise_edge6", {15'd0, Run}, 16'd1);
    check("release_no_pulse6", {15'd0, Run_pulse}, 16'd0);

    // Short Continue glitch is rejected
    Continue_n_raw = 1'b0;
    for (int i = 0; i < 3; i++) step();
    Continue_n_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("glitch_cont_level", {15'd0, Continue}, 16'd1);
      check("glitch_cont_pulse", {15'd0, Continue_pulse}, 16'd0);
    end

    // Switch synchronizer latency
    S_raw = 16'h004A;
    step();
    check("S_lat1", S, 16'h0000);
    step();
    check("S_4A", S, 16'h004A);
    S_raw = 16'h004B;
    step();
    check("S_lat1b", S, 16'h004A);
    step();
    check("S_4B", S, 16'h004B);

    // Reset in mid-debounce, key still held afterwards
    Run_n_raw = 1'b0;
    for (int i = 0; i < 3; i++) step();
    Reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    check("rst_run_high", {15'd0, Run}, 16'd1);
    step();
    step();
    Reset = 1'b0;
    npulse = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (Run_pulse === 1'b1) npulse++;
      if (i == 6) check("post_rst_pulse6", {15'd0, Run_pulse}, 16'd1);
    end
    check("post_rst_pulse_count", 16'(npulse), 16'd1);
    Run_n_raw = 1'b1;
    for (int i = 0; i < 8; i++) step();

    // Both keys pressed in the same cycle
    Run_n_raw = 1'b0;
    Continue_n_raw = 1'b0;
    for (int i = 0; i < 5; i++) step();
    step();
    check("both_run_pulse", {15'd0, Run_pulse}, 16'd1);
    check("both_cont_pulse", {15'd0, Continue_pulse}, 16'd1);
    step();
    check("both_run_pulse_end", {15'd0, Run_pulse}, 16'd0);
    check("both_cont_pulse_end", {15'd0, Continue_pulse}, 16'd0);
    Run_n_raw = 1'b1;
    Continue_n_raw = 1'b1;
    for (int i = 0; i < 8; i++) step();

    // Random bouncing keys, switch changes and occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 4) == 0) Run_n_raw = ~Run_n_raw;
      if ($urandom_range(0, 4) == 0) Continue_n_raw = ~Continue_n_raw;
      if ($urandom_range(0, 7) == 0) S_raw = 16'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        Reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        step();
        Reset = 1'b0;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

`default_nettype wire
